// File: rtl/alu_ctrl_mdu.sv
// rtl/alu_ctrl_mdu.sv - ALU control decode with an iterative multiply/divide unit
//
// Decodes ALUOp_i/funct_i into an ALU operation select and jr flag. R-type
// mult/multu/div/divu launch a WIDTH-iteration shift-add / restoring-divide
// sequence that writes HI/LO. mfhi/mflo read them back.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i             decode-stage instruction valid
//   ALUOp_i, funct_i    main-control ALU op class and R-type function field
//   src1_i, src2_i      rs / rt operands
//   ALUCtrl_o, jr_o     ALU select, jr decoded
//   busy_o              MDU sequencing
//   stall_o             hold PC and IF/ID this cycle
//   done_o              one-cycle pulse while HI/LO are being written
//   mf_sel_o, mf_data_o mfhi/mflo decoded, and the selected HI/LO value

module alu_ctrl_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [3:0]       ALUCtrl_o,
    output logic             jr_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             mf_sel_o,
    output logic [WIDTH-1:0] mf_data_o
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             sign_a;
    logic             sign_b;
    logic             op_div;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // ------------------------------------------------------------------
    // Instruction decode (combinational, independent of MDU state)
    // ------------------------------------------------------------------
    logic is_rtype;
    logic mdu_funct;
    logic mf_funct;
    logic launch;

    assign is_rtype  = (ALUOp_i == 3'd1);
    // 011000..011011 are mult, multu, div, divu
    assign mdu_funct = (funct_i[5:2] == 4'b0110);
    assign mf_funct  = (funct_i == FN_MFHI) || (funct_i == FN_MFLO);

    always_comb begin
        ALUCtrl_o = CTRL_AND;
        case (ALUOp_i)
            3'd1: begin
                case (funct_i)
                    FN_ADD:  ALUCtrl_o = CTRL_ADD;
                    FN_SUB:  ALUCtrl_o = CTRL_SUB;
                    FN_AND:  ALUCtrl_o = CTRL_AND;
                    FN_OR:   ALUCtrl_o = CTRL_OR;
                    FN_SLT:  ALUCtrl_o = CTRL_SLT;
                    default: ALUCtrl_o = CTRL_AND;
                endcase
            end
            3'd2, 3'd5, 3'd6: ALUCtrl_o = CTRL_ADD;
            3'd3:             ALUCtrl_o = CTRL_SLT;
            3'd4:             ALUCtrl_o = CTRL_SUB;
            default:          ALUCtrl_o = CTRL_AND;
        endcase
    end

    assign jr_o     = is_rtype && (funct_i == FN_JR);
    assign mf_sel_o = is_rtype && mf_funct;
    // mfhi has funct bit 1 clear, mflo has it set
    assign mf_data_o = funct_i[1] ? lo : hi;

    assign launch  = (state == S_IDLE) && valid_i && is_rtype && mdu_funct;
    assign busy_o  = (state != S_IDLE);
    assign done_o  = (state == S_FIN);
    assign stall_o = valid_i && is_rtype && (mdu_funct || mf_funct) && (busy_o || launch);

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    state_next = funct_i[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (count == CNT_W'(1)) begin
                    state_next = S_FIN;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // funct bit 0 set means the unsigned variant
    logic             in_signed;
    logic             in_sign_a;
    logic             in_sign_b;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;

    assign in_signed = ~funct_i[0];
    assign in_sign_a = in_signed & src1_i[WIDTH-1];
    assign in_sign_b = in_signed & src2_i[WIDTH-1];
    assign in_mag_a  = in_sign_a ? -src1_i : src1_i;
    assign in_mag_b  = in_sign_b ? -src2_i : src2_i;

    // Multiply: {acc,q} is the product register; q starts as the multiplier
    // and is shifted out LSB-first while partial sums shift in from the top.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc} + (q[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});

    // Restoring divide: q starts as the dividend and fills with quotient bits.
    // The partial remainder is always below the divisor, so the trial
    // subtraction result fits in WIDTH bits whenever it is kept.
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_sub;
    assign div_shift = {acc, q[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, mag_b});
    assign div_sub   = div_shift[WIDTH-1:0] - mag_b;

    // Sign correction applied in FIN
    logic               res_neg;
    logic               div_zero;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign res_neg  = sign_a ^ sign_b;
    assign div_zero = (mag_b == '0);
    assign prod     = {acc, q};
    assign prod_fix = res_neg ? -prod : prod;
    // A zero divisor yields an all-ones quotient and leaves |src1| as the
    // remainder; restoring the dividend's sign reproduces src1 exactly.
    assign quot_fix = div_zero ? '1 : (res_neg ? -q : q);
    assign rem_fix  = sign_a ? -acc : acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count  <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            op_div <= 1'b0;
            acc    <= '0;
            q      <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        mag_a  <= in_mag_a;
                        mag_b  <= in_mag_b;
                        sign_a <= in_sign_a;
                        sign_b <= in_sign_b;
                        op_div <= funct_i[1];
                        count  <= CNT_W'(WIDTH);
                        acc    <= '0;
                        q      <= funct_i[1] ? in_mag_a : in_mag_b;
                    end
                end
                S_MUL: begin
                    acc   <= mul_sum[WIDTH:1];
                    q     <= {mul_sum[0], q[WIDTH-1:1]};
                    count <= count - CNT_W'(1);
                end
                S_DIV: begin
                    if (div_ok) begin
                        acc <= div_sub;
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= div_shift[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end
                    count <= count - CNT_W'(1);
                end
                S_FIN: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb/tb_alu_ctrl_mdu.sv - self-checking bench for alu_ctrl_mdu

module tb_alu_ctrl_mdu;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  alu_ctrl;
    logic        jr;
    logic        busy;
    logic        stall;
    logic        done;
    logic        mf_sel;
    logic [31:0] mf_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_mdu #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .ALUOp_i   (aluop),
        .funct_i   (funct),
        .src1_i    (src1),
        .src2_i    (src2),
        .ALUCtrl_o (alu_ctrl),
        .jr_o      (jr),
        .busy_o    (busy),
        .stall_o   (stall),
        .done_o    (done),
        .mf_sel_o  (mf_sel),
        .mf_data_o (mf_data)
    );

    // Architectural result of an MDU op, from plain 64-bit arithmetic
    function automatic void ref_mdu(input logic [5:0] f, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint qq;
        longint rr;
        logic [63:0] p;
        case (f)
            F_MULT: begin
                p = sa * sb;
                hi = p[63:32]; lo = p[31:0];
            end
            F_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                hi = p[63:32]; lo = p[31:0];
            end
            F_DIV: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else begin
                    qq = sa / sb; rr = sa % sb;
                    lo = qq[31:0]; hi = rr[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [2:0] op, input logic [5:0] f);
        if (op == 3'd1) begin
            if (f == 6'b100000) return 4'b0010;
            if (f == 6'b100010) return 4'b0110;
            if (f == 6'b100100) return 4'b0000;
            if (f == 6'b100101) return 4'b0001;
            if (f == 6'b101010) return 4'b0111;
            return 4'b0000;
        end
        if (op == 3'd2 || op == 3'd5 || op == 3'd6) return 4'b0010;
        if (op == 3'd3) return 4'b0111;
        if (op == 3'd4) return 4'b0110;
        return 4'b0000;
    endfunction

    // Launches one MDU op, presents unstallable adds with scrambled operands
    // while it runs, then checks timing, done pulse and mfhi/mflo results.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int cyc;
        int done_cnt;
        int done_at;
        bit stall_bad;
        @(negedge clk);
        valid = 1'b1; aluop = 3'd1; funct = f; src1 = a; src2 = b;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL %s launch_stall got %b want 1", name, stall);
        end
        @(negedge clk);
        cyc = 0; done_cnt = 0; done_at = -1; stall_bad = 1'b0;
        while (busy === 1'b1 && cyc < 100) begin
            if (done === 1'b1) begin
                done_cnt++; done_at = cyc;
            end
            funct = 6'b100000; src1 = $urandom; src2 = $urandom;
            #1;
            if (stall !== 1'b0) stall_bad = 1'b1;
            cyc++;
            @(negedge clk);
        end
        valid = 1'b0;
        checks++;
        if (cyc != 33) begin
            errors++; $display("FAIL %s busy_cycles got %0d want 33", name, cyc);
        end
        checks++;
        if (done_cnt != 1 || done_at != 32) begin
            errors++; $display("FAIL %s done_pulse got count=%0d at=%0d want count=1 at=32", name, done_cnt, done_at);
        end
        checks++;
        if (stall_bad) begin
            errors++; $display("FAIL %s add_stalled got stall=1 want 0", name);
        end
        valid = 1'b1; funct = F_MFHI;
        #1;
        checks++;
        if (mf_sel !== 1'b1 || mf_data !== eh || stall !== 1'b0) begin
            errors++; $display("FAIL %s mfhi got sel=%b data=%h stall=%b want sel=1 data=%h stall=0", name, mf_sel, mf_data, stall, eh);
        end
        funct = F_MFLO;
        #1;
        checks++;
        if (mf_data !== el) begin
            errors++; $display("FAIL %s mflo got %h want %h", name, mf_data, el);
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; aluop = 3'd0; funct = 6'd0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clk);
        valid = 1'b1; aluop = 3'd1; funct = F_MFHI;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (mf_data !== 32'd0) begin
            errors++; $display("FAIL reset_hi got %h want 0", mf_data);
        end
        funct = F_MFLO;
        #1;
        checks++;
        if (mf_data !== 32'd0) begin
            errors++; $display("FAIL reset_lo got %h want 0", mf_data);
        end
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [5:0] flist [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};
        logic [5:0] f;
        logic [2:0] op;
        bit exp_jr;
        bit exp_mf;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            op = 3'($urandom_range(0, 7));
            if (i < 48) f = flist[i % 6];
            else f = 6'($urandom);
            if (f[5:2] == 4'b0110) f = 6'b000000;
            valid = 1'($urandom); aluop = op; funct = f;
            exp_jr = (op == 3'd1) && (f == 6'b001000);
            exp_mf = (op == 3'd1) && (f == F_MFHI || f == F_MFLO);
            #1;
            checks++;
            if (alu_ctrl !== ref_ctrl(op, f) || jr !== exp_jr || mf_sel !== exp_mf) begin
                errors++;
                $display("FAIL decode op=%0d funct=%b got ctrl=%b jr=%b mf=%b want ctrl=%b jr=%b mf=%b",
                         op, f, alu_ctrl, jr, mf_sel, ref_ctrl(op, f), exp_jr, exp_mf);
            end
            checks++;
            if (busy !== 1'b0 || stall !== 1'b0) begin
                errors++; $display("FAIL decode_idle got busy=%b stall=%b want 0 0", busy, stall);
            end
        end
        valid = 1'b0; aluop = 3'd0;
    endtask

    task automatic test_directed();
        run_op(F_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3_5");
        run_op(F_DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, "divu_100_7");
        run_op(F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_m1");
        run_op(F_DIV,   32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, "div_by_zero");
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    endtask

    task automatic test_random_mdu();
        logic [31:0] specials [4] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic [5:0]  f;
        for (int i = 0; i < 40; i++) begin
            f = {4'b0110, 2'($urandom_range(0, 3))};
            a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(0, 31);
            ref_mdu(f, a, b, eh, el);
            run_op(f, a, b, eh, el, $sformatf("rand%0d_f%b", i, f));
        end
    endtask

    task automatic test_stall_mf();
        logic [31:0] a = 32'h8765_4321;
        logic [31:0] b = 32'hFEDC_BA98;
        logic [31:0] eh;
        logic [31:0] el;
        int cyc;
        bit stall_bad;
        ref_mdu(F_MULT, a, b, eh, el);
        @(negedge clk);
        valid = 1'b1; aluop = 3'd1; funct = F_MULT; src1 = a; src2 = b;
        @(negedge clk);
        funct = F_MFLO;
        cyc = 0; stall_bad = 1'b0;
        while (busy === 1'b1 && cyc < 100) begin
            #1;
            if (stall !== 1'b1) stall_bad = 1'b1;
            cyc++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (stall_bad || cyc != 33) begin
            errors++; $display("FAIL stall_hold got bad=%b cycles=%0d want bad=0 cycles=33", stall_bad, cyc);
        end
        checks++;
        if (stall !== 1'b0 || mf_sel !== 1'b1 || mf_data !== el) begin
            errors++; $display("FAIL stall_release got stall=%b sel=%b data=%h want 0 1 %h", stall, mf_sel, mf_data, el);
        end
        valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int done_seen;
        int busy_seen;
        @(negedge clk);
        valid = 1'b1; aluop = 3'd1; funct = F_DIVU; src1 = 32'hDEAD_BEEF; src2 = 32'd3;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL midrst_busy got %b want 0", busy);
        end
        valid = 1'b1; funct = F_MFHI;
        #1;
        checks++;
        if (mf_data !== 32'd0) begin
            errors++; $display("FAIL midrst_hi got %h want 0", mf_data);
        end
        funct = F_MFLO;
        #1;
        checks++;
        if (mf_data !== 32'd0) begin
            errors++; $display("FAIL midrst_lo got %h want 0", mf_data);
        end
        valid = 1'b0;
        done_seen = 0; busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        checks++;
        if (done_seen != 0 || busy_seen != 0) begin
            errors++; $display("FAIL midrst_quiet got done=%0d busy=%0d want 0 0", done_seen, busy_seen);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_directed();
        test_random_mdu();
        test_stall_mf();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
Parametrised ALU controller with an integrated iterative multiply/divide unit (MDU) for the single-issue MIPS datapath.
- Decodes ALUOp_i/funct_i into ALUCtrl_o and jr_o, as the current ALU controller does.
- Adds R-type mult/multu/div/divu, run as a WIDTH-cycle shift-add / restoring-divide sequencer that writes HI/LO.
- Adds mfhi/mflo readout and a stall output that holds the front end while the MDU is busy.

Parameters:
WIDTH, 32, operand width; HI, LO and operands are WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  instruction in decode is valid
ALUOp_i  in  3  1=R-type, 2=addi, 3=slti, 4=beq, 5=lw, 6=sw, 0/7=nop
funct_i  in  6  R-type function field
src1_i  in  WIDTH  rs operand (dividend / multiplicand)
src2_i  in  WIDTH  rt operand (divisor / multiplier)
ALUCtrl_o  out  4  ALU operation select
jr_o  out  1  jr decoded
busy_o  out  1  MDU sequencing (registered)
stall_o  out  1  hold PC/IF-ID this cycle
done_o  out  1  one-cycle pulse when HI/LO are written
mf_sel_o  out  1  mfhi/mflo decoded; datapath writes mf_data_o to rd
mf_data_o  out  WIDTH  HI for mfhi, LO for mflo

Behaviour:
- ALUCtrl_o encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- ALUOp_i=1 decode: funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct gives 0000.
- Other ALUOp_i values: 2/5/6 give ADD, 3 gives SLT, 4 gives SUB, 0/7 give 0000.
- Decode is purely combinational; it does not depend on valid_i or MDU state.
- jr_o = (ALUOp_i==1 && funct_i==001000), combinational.
- MDU functs: 011000 mult, 011001 multu, 011010 div, 011011 divu. mf functs: 010000 mfhi, 010010 mflo.
- mf_sel_o = ALUOp_i==1 && funct is mfhi or mflo. mf_data_o is always the current HI/LO register value.
- FSM states: IDLE, MUL, DIV, FIN.
  - launch = IDLE && valid_i && ALUOp_i==1 && MDU funct.
  - On launch: latch operand magnitudes (signed ops use |x|; unsigned ops use raw values), latch the sign of each operand and the op type, set count=WIDTH, go to MUL or DIV.
  - MUL/DIV: one bit per cycle, count decrements; go to FIN when count reaches 1 and that iteration completes.
  - FIN: apply sign correction, write HI/LO, pulse done_o, return to IDLE.
- Latency: launch at edge N; busy_o high from N+1 through the FIN cycle (WIDTH+1 cycles). HI/LO are written at edge N+WIDTH+1. done_o is high during the FIN cycle.
- stall_o = valid_i && ALUOp_i==1 && (MDU funct or mf funct) && (busy_o || launch).
  - Consequence: the launching instruction is held, then re-presented and accepted as a no-op once IDLE returns. Launch fires only from IDLE, and a held command must not relaunch after FIN, so the issuing pipeline clears valid_i on the cycle after done_o for that instruction.
  - Non-MDU instructions are never stalled.
- Multiply: full 2*WIDTH-bit product into {HI,LO}. For signed ops the product is negated when the operand signs differ.
- Divide: LO = quotient, HI = remainder. For signed ops the quotient is negated when signs differ, and the remainder takes the dividend's sign.
- Divide by zero: takes the same latency; LO = all ones, HI = src1 as latched at launch; no sign correction.
- Signed MIN / -1: LO = MIN, HI = 0 (falls out of magnitude arithmetic; no special case).
- Reset (any state, including mid-operation): state IDLE, HI=LO=0, count=0, busy_o=0, done_o=0. An in-flight operation is discarded and no done_o is produced.
- Operand changes after launch have no effect on the result.

Test Plan:
- Decode sweep: every ALUOp_i with add/sub/and/or/slt/jr functs -> ALUCtrl_o per table; jr_o only for ALUOp_i=1, funct 001000; busy_o stays 0.
- WIDTH=32, mult, src1=-3, src2=5 -> busy_o for 33 cycles, done_o pulse, HI=FFFFFFFF, LO=FFFFFFF1; mfhi gives mf_sel_o=1, mf_data_o=FFFFFFFF.
- divu 100/7 -> LO=0000000E, HI=00000002. div -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. div 80000000/FFFFFFFF -> LO=80000000, HI=0.
- div 12345678/0 -> after 33 cycles LO=FFFFFFFF, HI=12345678.
- mult launched, then mflo held with valid_i=1 -> stall_o=1 every cycle through FIN, 0 the following cycle; mf_data_o equals the new LO.
- rst_i asserted 10 cycles into divu -> next cycle busy_o=0, HI=LO=0; no done_o over the following 40 cycles.
